// File: rtl/io_map_pkg.sv
// Address map and display constants shared by the I/O output block.
// Used by io_output_reg and hex_to_seg7.
package io_map_pkg;

    localparam logic [5:0] IO_OUT0 = 6'b100000;
    localparam logic [5:0] IO_OUT1 = 6'b100001;
    localparam logic [5:0] IO_OUT2 = 6'b100010;
    localparam logic [5:0] IO_IN0  = 6'b110000;
    localparam logic [5:0] IO_IN1  = 6'b110001;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int DIGIT_W = 3;
    typedef logic [DIGIT_W-1:0] digit_idx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment code, segment order {g,f,e,d,c,b,a}.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg7
    import io_map_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/io_output_reg.sv
// Memory-mapped output registers plus 8-digit scanned hex display of out_port2.
// Latency: store visible on out_portN and io_wr_ack one cycle after the strobe.
// Backpressure: none, every store accepted. IO_READBACK_EN adds io_read_data.
module io_output_reg
    import io_map_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        write_io_enable,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic        io_wr_ack,
    output logic [7:0]  hex_an,
`ifdef IO_READBACK_EN
    output logic [6:0]  hex_seg,
    output logic [31:0] io_read_data
`else
    output logic [6:0]  hex_seg
`endif
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [5:0]       reg_sel;
    logic             map_hit;
    logic [CNT_W-1:0] scan_cnt, scan_cnt_nxt;
    digit_idx_t       digit_idx, digit_idx_nxt;
    logic [3:0]       seg_nibble;
    logic [6:0]       seg_nxt;
    logic             unused_addr;

    assign reg_sel     = addr[7:2];
    assign unused_addr = ^{addr[31:8], addr[1:0]};
    assign map_hit     = (reg_sel == IO_OUT0) || (reg_sel == IO_OUT1) || (reg_sel == IO_OUT2);

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            out_port0 <= '0;
            out_port1 <= '0;
            out_port2 <= '0;
            io_wr_ack <= 1'b0;
        end else begin
            io_wr_ack <= write_io_enable && map_hit;
            if (write_io_enable) begin
                case (reg_sel)
                    IO_OUT0: out_port0 <= datain;
                    IO_OUT1: out_port1 <= datain;
                    IO_OUT2: out_port2 <= datain;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        scan_cnt_nxt  = scan_cnt + 1'b1;
        digit_idx_nxt = digit_idx;
        if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_nxt  = '0;
            digit_idx_nxt = (digit_idx == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
        end
    end

    // Display outputs are registered from the next index so hex_an and hex_seg switch together.
    assign seg_nibble = out_port2[{digit_idx_nxt, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (seg_nibble),
        .seg    (seg_nxt)
    );

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            hex_an    <= 8'b1111_1110;
            hex_seg   <= 7'b1000000;
        end else begin
            scan_cnt  <= scan_cnt_nxt;
            digit_idx <= digit_idx_nxt;
            hex_an    <= ~(8'b1 << digit_idx_nxt);
            hex_seg   <= seg_nxt;
        end
    end

`ifdef IO_READBACK_EN
    always_comb begin
        io_read_data = '0;
        case (reg_sel)
            IO_OUT0: io_read_data = out_port0;
            IO_OUT1: io_read_data = out_port1;
            IO_OUT2: io_read_data = out_port2;
            default: io_read_data = '0;
        endcase
    end
`endif

endmodule
